ps2_game_decoder: RTL and testbench
===================================

PS2_GAME_DECODER -- requirements
Module: ps2_game_decoder

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players decoded, legal 1..4.
REQ-002 Parameter KEYMAP, width NUM_PLAYERS*5*9, default {P2: E0 75, E0 72, E0 6B, E0 74, 4C; P1: 1D, 1B, 1C, 23, 3B}, per key 9 bits {ext, scancode}, key k of player p at bits [(p*5+k)*9 +: 9].
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, board_clk cycles allowed between PS/2 falling edges inside a frame.
REQ-004 board_clk  input  1  system clock; sole clock of the block.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock, asynchronous to board_clk.
REQ-007 ps2_data  input  1  raw PS/2 data, asynchronous to board_clk.
REQ-008 clear_keys  input  1  synchronous request to release all keys.
REQ-009 keys  output  NUM_PLAYERS*5  held-key state; per player bits 0..4 = up, down, left, right, shoot.
REQ-010 code  output  8  last correctly received byte.
REQ-011 code_valid  output  1  one-cycle pulse, code updated.
REQ-012 frame_err  output  1  one-cycle pulse, frame discarded.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a frame bit SHALL be sampled on the cycle a synchronized 1->0 ps2_clk transition is detected.
REQ-014 Receiver SHALL shift an 11-bit frame: start(0), 8 data bits LSB first, odd parity, stop(1); bit counter 0..10, returns to 0 after the stop bit.
REQ-015 A frame SHALL be accepted only if start=0, stop=1 and data+parity has odd weight; otherwise frame_err pulses, code and decoder state unchanged.
REQ-016 On acceptance, code and code_valid SHALL update in the cycle after the stop-bit edge is detected (latency 1 board_clk from stop-bit sample).
REQ-017 Decoder FSM states IDLE, EXT, BRK, EXT_BRK; transitions on each accepted byte: E0 from IDLE->EXT; F0 from IDLE->BRK, from EXT->EXT_BRK; any other byte -> IDLE.
REQ-018 A non-prefix byte SHALL be matched against every KEYMAP entry with ext = (state in EXT or EXT_BRK); each matching key bit is set (IDLE/EXT) or cleared (BRK/EXT_BRK).
REQ-019 keys SHALL update in the same cycle code_valid asserts; bytes matching no entry (including AA, FA, E1) change no key bits.
REQ-020 Duplicate KEYMAP entries SHALL all update together; repeated make codes (typematic) leave a held bit at 1.
REQ-021 clear_keys SHALL zero keys on the next edge and force the FSM to IDLE; when coincident with a decoded byte, clear wins; the receiver shift state is unaffected.
REQ-022 An E0 or F0 followed by a rejected frame SHALL keep its prefix state for the next accepted byte.

Reset
REQ-023 reset SHALL asynchronously force keys=0, code=8'h00, code_valid=0, frame_err=0, FSM=IDLE, bit counter=0, synchronizer flops=1 (bus idle).
REQ-024 Reset released mid-frame SHALL discard that frame's remaining bits until a later start bit; no spurious key change occurs.

Configuration
REQ-025 Macro PS2_GAME_DECODER_TIMEOUT_EN defined: a counter SHALL reset the bit counter to 0 and pulse frame_err when TIMEOUT_CYCLES elapse with bit counter non-zero and no falling edge; counter clears on each edge.
REQ-026 Macro undefined: no timeout logic; a partial frame persists until its remaining edges arrive.

Verification
REQ-027 Frame 1D (W), valid parity -> code=1D, code_valid 1 pulse, keys[0]=1, all other bits 0.
REQ-028 Bytes E0,75 then E0,F0,75 -> keys[5] rises after 75, falls after second 75; keys[0] unaffected.
REQ-029 Frame 23 with even parity -> frame_err 1 pulse, code unchanged, keys[3] stays 0.
REQ-030 Hold W and D, assert clear_keys in the cycle code_valid for 1C pulses -> keys=0, FSM IDLE.
REQ-031 With TIMEOUT_EN, send 4 bits then stall 50001 cycles, then full frame 3B -> one frame_err, then keys[4]=1.
REQ-032 Assert reset mid-frame with keys[0]=1 -> keys=0 immediately; next full frame 1B sets keys[1] only.

Source files
------------

// File: rtl/ps2_game_decoder.sv
// PS/2 keyboard receiver and game-key decoder: frames, checks and decodes
// scancodes into held up/down/left/right/shoot bits for up to 4 players.
// Ports:
//   board_clk, reset      - system clock, async active-high reset
//   ps2_clk, ps2_data     - raw asynchronous PS/2 bus lines
//   clear_keys            - synchronous request to release all keys
//   keys                  - held keys, 5 bits per player (up,down,left,right,shoot)
//   code, code_valid      - last good byte and its one-cycle strobe
//   frame_err             - one-cycle strobe for a discarded frame
// Optional: define PS2_GAME_DECODER_TIMEOUT_EN to abort stalled frames
// after TIMEOUT_CYCLES board_clk cycles without a PS/2 falling edge.
module ps2_game_decoder #(
  parameter int NUM_PLAYERS = 2,
  parameter logic [NUM_PLAYERS*45-1:0] KEYMAP = {
    9'h04C, 9'h174, 9'h16B, 9'h172, 9'h175,
    9'h03B, 9'h023, 9'h01C, 9'h01B, 9'h01D
  },
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     board_clk,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     clear_keys,
  output logic [NUM_PLAYERS*5-1:0] keys,
  output logic [7:0]               code,
  output logic                     code_valid,
  output logic                     frame_err
);

  localparam int NK = NUM_PLAYERS * 5;

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4 || TIMEOUT_CYCLES < 1)
  begin : g_cfg_check
    $error("ps2_game_decoder: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       fall;
  logic       bit_in;

  logic [3:0] bit_cnt;
  logic [9:0] shreg;
  logic       frame_done;
  logic       frame_ok;
  logic [7:0] rx_byte;
  logic       timeout;

  state_t     state;
  logic       ext_mode;
  logic       brk_mode;
  logic [NK-1:0] hit;

  // Sync flops reset to 1 so that releasing reset on an idle bus
  // cannot manufacture a falling edge.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = data_sync[1];

  assign frame_done = fall && (bit_cnt == 4'd10);
  assign rx_byte    = shreg[8:1];
  // start low, stop high, data+parity odd weight
  assign frame_ok   = ~shreg[0] & bit_in & (^shreg[9:1]);

  // Bits shift in from the top; after ten shifts the start bit sits in
  // shreg[0] and parity in shreg[9]. The stop bit is taken live.
  // While idle, a high sample is not a start bit and is ignored, so a
  // frame cut by reset is dropped until a real start bit appears.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= 4'd0;
      shreg   <= 10'd0;
    end else if (fall) begin
      if (bit_cnt == 4'd0) begin
        if (!bit_in) begin
          shreg   <= {bit_in, shreg[9:1]};
          bit_cnt <= 4'd1;
        end
      end else if (bit_cnt == 4'd10) begin
        bit_cnt <= 4'd0;
      end else begin
        shreg   <= {bit_in, shreg[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (timeout) begin
      bit_cnt <= 4'd0;
    end
  end

`ifdef PS2_GAME_DECODER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;

  assign timeout = (bit_cnt != 4'd0) && !fall &&
                   (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (fall || bit_cnt == 4'd0 || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign ext_mode = (state == EXT) || (state == EXT_BRK);
  assign brk_mode = (state == BRK) || (state == EXT_BRK);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NK; i++) begin
      hit[i] = (KEYMAP[i*9 +: 9] == {ext_mode, rx_byte});
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      keys       <= '0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      state      <= IDLE;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= (frame_done && !frame_ok) || timeout;
      if (frame_done && frame_ok) begin
        code       <= rx_byte;
        code_valid <= 1'b1;
      end
      if (clear_keys) begin
        keys  <= '0;
        state <= IDLE;
      end else if (frame_done && frame_ok) begin
        unique case (1'b1)
          (rx_byte == 8'hE0): begin
            state <= (state == IDLE) ? EXT : IDLE;
          end
          (rx_byte == 8'hF0): begin
            unique case (state)
              IDLE:    state <= BRK;
              EXT:     state <= EXT_BRK;
              default: state <= IDLE;
            endcase
          end
          default: begin
            keys  <= brk_mode ? (keys & ~hit) : (keys | hit);
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_game_decoder.sv
// Self-checking bench for ps2_game_decoder: directed vector table,
// hand sequences for clear/reset corners, then random bytes vs a model.
module tb_ps2_game_decoder;

  localparam int NK = 10;

  logic          board_clk = 1'b0;
  logic          reset;
  logic          ps2_clk;
  logic          ps2_data;
  logic          clear_keys;
  logic [NK-1:0] keys;
  logic [7:0]    code;
  logic          code_valid;
  logic          frame_err;

  ps2_game_decoder #(.NUM_PLAYERS(2)) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .clear_keys (clear_keys),
    .keys       (keys),
    .code       (code),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  always #5 board_clk = ~board_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;

  always @(negedge board_clk) begin
    if (code_valid) n_valid++;
    if (frame_err) n_err++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  bit clr_on_valid = 0;
  bit clr_fired = 0;

  task automatic tick();
    @(negedge board_clk);
    if (clr_on_valid && !clr_fired && code_valid) begin
      clear_keys = 1'b1;
      clr_fired  = 1'b1;
    end else begin
      clear_keys = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (5) tick();
    ps2_clk = 1'b0;
    repeat (5) tick();
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad);
    send_bit(1'b1);
    repeat (3) tick();
  endtask

  task automatic pulse_clear();
    @(negedge board_clk);
    clear_keys = 1'b1;
    @(negedge board_clk);
    clear_keys = 1'b0;
  endtask

  // Reference model: held-key bits plus two pending-prefix flags.
  logic [8:0] km [NK] = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h03B,
                          9'h175, 9'h172, 9'h16B, 9'h174, 9'h04C};
  bit [NK-1:0] m_keys;
  bit          m_ext;
  bit          m_brk;
  logic [7:0]  m_code;

  task automatic model_reset();
    m_keys = '0;
    m_ext  = 0;
    m_brk  = 0;
    m_code = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_code = b;
    if (b == 8'hE0) begin
      if (!m_ext && !m_brk) m_ext = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (b == 8'hF0) begin
      if (!m_brk) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else begin
      for (int i = 0; i < NK; i++)
        if (km[i] == {m_ext, b}) m_keys[i] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge board_clk);
    reset = 1'b1;
    repeat (2) @(negedge board_clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0]  b;
    bit          bad;
    logic [9:0]  k;
    logic [7:0]  c;
    int          dv;
    int          de;
  } vec_t;

  vec_t tv [20];

  initial begin
    int v0, e0;
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    clear_keys = 1'b0;
    model_reset();

    tv = '{
      '{8'h1D, 0, 10'h001, 8'h1D, 1, 0},
      '{8'h23, 1, 10'h001, 8'h1D, 0, 1},
      '{8'hE0, 0, 10'h001, 8'hE0, 1, 0},
      '{8'h75, 0, 10'h021, 8'h75, 1, 0},
      '{8'hE0, 0, 10'h021, 8'hE0, 1, 0},
      '{8'hF0, 0, 10'h021, 8'hF0, 1, 0},
      '{8'h75, 0, 10'h001, 8'h75, 1, 0},
      '{8'hF0, 0, 10'h001, 8'hF0, 1, 0},
      '{8'h23, 1, 10'h001, 8'hF0, 0, 1},
      '{8'h1D, 0, 10'h000, 8'h1D, 1, 0},
      '{8'hAA, 0, 10'h000, 8'hAA, 1, 0},
      '{8'h1D, 0, 10'h001, 8'h1D, 1, 0},
      '{8'h1D, 0, 10'h001, 8'h1D, 1, 0},
      '{8'hE0, 0, 10'h001, 8'hE0, 1, 0},
      '{8'h4C, 0, 10'h001, 8'h4C, 1, 0},
      '{8'h4C, 0, 10'h201, 8'h4C, 1, 0},
      '{8'hF0, 0, 10'h201, 8'hF0, 1, 0},
      '{8'h4C, 0, 10'h001, 8'h4C, 1, 0},
      '{8'hE1, 0, 10'h001, 8'hE1, 1, 0},
      '{8'hFA, 0, 10'h001, 8'hFA, 1, 0}
    };

    repeat (3) @(negedge board_clk);
    #1;
    check("reset_keys", 32'(keys), 0);
    check("reset_code", 32'(code), 0);
    check("reset_valid", 32'(code_valid), 0);
    check("reset_err", 32'(frame_err), 0);
    @(negedge board_clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(tv[i].b, tv[i].bad);
      check($sformatf("vec%0d_keys", i), 32'(keys), 32'(tv[i].k));
      check($sformatf("vec%0d_code", i), 32'(code), 32'(tv[i].c));
      check($sformatf("vec%0d_valid", i), n_valid - v0, tv[i].dv);
      check($sformatf("vec%0d_err", i), n_err - e0, tv[i].de);
    end

    // D pressed, then clear on the strobe of A: everything released.
    send_frame(8'h23, 0);
    check("hold_wd", 32'(keys), 32'h009);
    clr_on_valid = 1;
    clr_fired = 0;
    send_frame(8'h1C, 0);
    clr_on_valid = 0;
    check("clear_fired", 32'(clr_fired), 1);
    check("clear_keys", 32'(keys), 0);
    // Pending break prefix is dropped by clear: 1D makes, not breaks.
    send_frame(8'hF0, 0);
    pulse_clear();
    send_frame(8'h1D, 0);
    check("clear_idle", 32'(keys), 32'h001);

    // Reset mid-frame while W held.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge board_clk);
    reset = 1'b1;
    #1;
    check("midrst_keys", 32'(keys), 0);
    check("midrst_code", 32'(code), 0);
    repeat (2) @(negedge board_clk);
    reset = 1'b0;
    send_frame(8'h1B, 0);
    check("postrst_keys", 32'(keys), 32'h002);
    check("postrst_code", 32'(code), 32'h1B);

`ifdef PS2_GAME_DECODER_TIMEOUT_EN
    do_reset();
    e0 = n_err;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    repeat (50001) @(negedge board_clk);
    send_frame(8'h3B, 0);
    check("timeout_err", n_err - e0, 1);
    check("timeout_keys", 32'(keys), 32'h010);
`endif

    do_reset();
    for (int it = 0; it < 150; it++) begin
      logic [7:0] b;
      bit bad;
      int r;
      r = $urandom_range(0, 9);
      bad = 0;
      unique case (r)
        0, 1, 2, 3: b = km[$urandom_range(0, NK - 1)][7:0];
        4: b = 8'hE0;
        5: b = 8'hF0;
        6: b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
        7: b = 8'($urandom);
        8: begin b = 8'($urandom); bad = 1; end
        default: b = 8'h00;
      endcase
      v0 = n_valid;
      e0 = n_err;
      if (r == 9) begin
        pulse_clear();
        m_keys = '0;
        m_ext = 0;
        m_brk = 0;
        check($sformatf("rnd%0d_clr", it), 32'(keys), 0);
      end else begin
        send_frame(b, bad);
        if (!bad) model_byte(b);
        check($sformatf("rnd%0d_keys", it), 32'(keys), 32'(m_keys));
        check($sformatf("rnd%0d_code", it), 32'(code), 32'(m_code));
        check($sformatf("rnd%0d_valid", it), n_valid - v0, bad ? 0 : 1);
        check($sformatf("rnd%0d_err", it), n_err - e0, bad ? 1 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
